// File: rtl/ma_load.sv
// ============================================================================
// Module   : ma_load
// Purpose  : Memory-access load path: word-aligned RAM read, byte/half/word
//            extraction with sign/zero extension, stall and misalign flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_load #(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dram_rd_en_i,
  input  logic [2:0]      dram_rd_sel_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  output logic            busy_o,
  output logic            dram_rd_req_o,
  output logic [XLEN-1:0] dram_rd_addr_o,
  input  logic [31:0]     dram_rd_data_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_valid_o,
  output logic            misalign_o
);

  localparam logic [2:0] c_lat = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      r_sel;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic            r_valid;
  logic            r_misalign;

  logic            w_legal;
  logic            w_aligned;
  logic            w_idle_req;
  logic            w_accept;
  logic            w_misalign;
  logic            w_sample;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ext;

  always_comb begin
    w_legal = 1'b0;
    case (dram_rd_sel_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
      default:                                w_legal = 1'b0;
    endcase
  end

  // Byte loads never misalign; sel[1:0] distinguishes half (01) from word (10)
  always_comb begin
    w_aligned = 1'b1;
    case (dram_rd_sel_i[1:0])
      2'b01:   w_aligned = ~dram_rd_addr_i[0];
      2'b10:   w_aligned = (dram_rd_addr_i[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_idle_req = (r_state == S_IDLE) & dram_rd_en_i & w_legal;
  assign w_accept   = w_idle_req & w_aligned;
  assign w_misalign = w_idle_req & ~w_aligned;
  assign w_sample   = (r_state == S_WAIT) && (r_cnt == 3'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = dram_rd_data_i[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = dram_rd_data_i[7:0];
      2'd1: w_byte = dram_rd_data_i[15:8];
      2'd2: w_byte = dram_rd_data_i[23:16];
      2'd3: w_byte = dram_rd_data_i[31:24];
      default: w_byte = dram_rd_data_i[7:0];
    endcase
    w_half = r_addr[1] ? dram_rd_data_i[31:16] : dram_rd_data_i[15:0];
  end

  always_comb begin
    w_ext = XLEN'(dram_rd_data_i);
    case (r_sel)
      3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_ext = XLEN'(dram_rd_data_i);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= 3'd0;
      r_sel      <= 3'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel  <= dram_rd_sel_i;
        r_addr <= dram_rd_addr_i;
      end
      if (r_state == S_REQ)       r_cnt <= c_lat;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_sample) r_data <= w_ext;
      r_valid    <= w_sample;
      r_misalign <= w_misalign;
    end
  end

  assign busy_o         = (r_state != S_IDLE) | w_accept;
  assign dram_rd_req_o  = (r_state == S_REQ);
  assign dram_rd_addr_o = {r_addr[XLEN-1:2], 2'b00};
  assign rd_data_o      = r_data;
  assign rd_valid_o     = r_valid;
  assign misalign_o     = r_misalign;

endmodule

`default_nettype wire

// File: doc/ma_load.md
# ma_load

Load-side companion of the memory-access stage. It accepts one load request from the pipeline, issues a word-aligned read to the data RAM, and waits a fixed, parameterised RAM read latency. It then extracts the addressed byte, halfword or word, sign- or zero-extends it to XLEN, and returns it with a one-cycle valid pulse. While a load is in flight it stalls the pipeline, and it flags misaligned loads without touching the RAM.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RD_LAT, 1, data-RAM read latency in cycles, counted from the request cycle to the cycle data is valid; legal range 1..4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- dram_rd_en_i  in  1  load request from the pipeline; sampled only while IDLE.
- dram_rd_sel_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal.
- dram_rd_addr_i  in  XLEN  byte address of the load.
- busy_o  out  1  pipeline stall.
- dram_rd_req_o  out  1  one-cycle read strobe to the RAM.
- dram_rd_addr_o  out  XLEN  word-aligned RAM address, {addr[XLEN-1:2],2'b00}.
- dram_rd_data_i  in  32  RAM read data; valid RD_LAT cycles after dram_rd_req_o.
- rd_data_o  out  XLEN  extended load result; held until the next result.
- rd_valid_o  out  1  one-cycle pulse, rd_data_o is new.
- misalign_o  out  1  one-cycle pulse, the load was misaligned.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE, dram_rd_en_i=1, legal select, aligned address:
  - latch sel and addr;
  - next state REQ.
- Alignment rules: LH/LHU require addr[0]=0; LW requires addr[1:0]=0; LB/LBU are always aligned.
- IDLE, dram_rd_en_i=1, legal select, misaligned address:
  - misalign_o=1 on the next cycle;
  - no RAM request; rd_data_o unchanged; stay in IDLE.
- IDLE, dram_rd_en_i=1, illegal select:
  - ignored: no request, no valid, no misalign.
- REQ:
  - dram_rd_req_o=1 and dram_rd_addr_o driven;
  - latency counter loaded with RD_LAT;
  - next state WAIT.
- WAIT:
  - counter decrements every cycle;
  - in the cycle the counter reaches 1 (RD_LAT cycles after REQ), sample dram_rd_data_i, extract, extend and register into rd_data_o; set rd_valid_o for the next cycle; next state IDLE.
- Extraction, with off = addr[1:0]:
  - B: data[8*off+7:8*off];
  - H: data[16*addr[1]+15:16*addr[1]];
  - W: the whole word.
- Extension: LB/LH replicate the MSB of the extracted field; LBU/LHU zero-fill.
- dram_rd_en_i outside IDLE is ignored; the pipeline holds the request under busy_o.
- dram_rd_data_i outside the sample cycle is ignored.
- dram_rd_addr_o is held from REQ until the next accepted request.

## Timing
- Request accepted at cycle T:
  - dram_rd_req_o at T+1;
  - data sampled at T+1+RD_LAT;
  - rd_valid_o at T+2+RD_LAT.
- Request-to-result latency is RD_LAT+2; throughput is one load per RD_LAT+2 cycles. A new request may be accepted in the same cycle rd_valid_o is high.
- busy_o = (state!=IDLE) | (IDLE & dram_rd_en_i & legal select & aligned). It is high from T through T+1+RD_LAT and low at T+2+RD_LAT.
- A misaligned or illegal request never raises busy_o.
- Reset values:
  - state IDLE; counter 0;
  - busy_o 0 when dram_rd_en_i=0; dram_rd_req_o 0; dram_rd_addr_o 0;
  - rd_data_o 0; rd_valid_o 0; misalign_o 0.
- Reset mid-operation (REQ or WAIT): the next cycle is IDLE with all outputs at reset values. The in-flight load is dropped and late RAM data never produces rd_valid_o.

## Test plan
- LW, addr 0x100, RAM word 0x8765_4321, RD_LAT=1: dram_rd_req_o at T+1 with addr 0x100; rd_valid_o at T+3 with rd_data_o=0x8765_4321; busy_o high T..T+2.
- LB addr 0x103 -> 0xFFFF_FF87; LBU addr 0x103 -> 0x0000_0087; LH addr 0x102 -> 0xFFFF_8765; LHU addr 0x100 -> 0x0000_4321 (same RAM word).
- LW addr 0x102, then LH addr 0x101: misalign_o pulses the next cycle each time; no dram_rd_req_o; busy_o stays 0; rd_data_o unchanged.
- RD_LAT=3, two back-to-back LW requests held under busy_o: rd_valid_o at T+5 and T+10; dram_rd_data_i garbage outside the sample cycles does not affect results.
- rst_i asserted during WAIT: IDLE the next cycle, no rd_valid_o for the dropped load; a subsequent LW completes normally.
- Illegal sel 3'b011 with dram_rd_en_i=1: no request, busy_o 0, no valid, no misalign.
